// File: rtl/periph_bus_master_if.sv
// Peripheral bus master bundle: CPU-side request/response plus
// the initiator side of the memory-mapped peripheral bus.
interface periph_bus_master_if;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic         cpu_busy;
  logic [3:0]   per_wen;
  logic [31:0]  per_addr;
  logic [31:0]  per_wdata;
  logic [127:0] per_rdata;

  modport master (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ready,
    output cpu_rdata,
    output cpu_err,
    output cpu_busy,
    output per_wen,
    output per_addr,
    output per_wdata,
    input  per_rdata
  );

  modport slave (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ready,
    input  cpu_rdata,
    input  cpu_err,
    input  cpu_busy,
    input  per_wen,
    input  per_addr,
    input  per_wdata,
    output per_rdata
  );
endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: one CPU request at a time, slot decode,
// registered-read latency wait, single-cycle ready/err response.
module periph_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int unsigned RD_LAT    = 1
) (
  input logic                 clk,
  input logic                 rst,
  periph_bus_master_if.master bus
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_lat
    $error("periph_bus_master: RD_LAT must be 1..15");
  end

  localparam logic [3:0] LP_LAT = 4'(RD_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [3:0]  r_cnt;

  logic        w_hit;
  logic [1:0]  w_slot;
  logic [3:0]  w_onehot;
  logic [31:0] w_slot_data;
  logic        w_accept;
  logic        w_load;
  logic        w_capture;
  logic        w_clr;
  logic        w_busy;
  logic        w_ready;
  logic        w_err;
  logic [3:0]  w_wen;

  // Decode always works on the latched address, never the live CPU bus.
  assign w_hit = (r_addr[31:8] == BASE_ADDR[31:8])
              && (r_addr[7:6] == 2'b00);
  assign w_slot = r_addr[5:4];
  assign w_onehot = 4'b0001 << w_slot;
  assign w_slot_data = bus.per_rdata[{w_slot, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (w_load) begin
        r_cnt <= LP_LAT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_rdata <= w_slot_data;
      end else if (w_clr) begin
        r_rdata <= '0;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_clr     = 1'b0;
    w_wen     = 4'b0000;
    w_busy    = 1'b1;
    w_ready   = 1'b0;
    w_err     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.cpu_req) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we && w_hit) begin
          w_wen = w_onehot;
        end
        if (w_hit && !r_we) begin
          w_load = 1'b1;
          w_next = S_WAIT;
        end else begin
          w_clr  = !w_hit;
          w_next = S_RESP;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        w_ready = 1'b1;
        w_err   = !w_hit;
        w_next  = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.cpu_ready = w_ready;
  assign bus.cpu_err   = w_err;
  assign bus.cpu_busy  = w_busy;
  assign bus.cpu_rdata = r_rdata;
  assign bus.per_wen   = w_wen;
  assign bus.per_addr  = r_addr;
  assign bus.per_wdata = r_wdata;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench: two masters (RD_LAT 1 and 3) share one CPU stimulus
// stream; each has its own registered responder and expectation queue.
module tb_periph_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  periph_bus_master_if bus0 ();
  periph_bus_master_if bus1 ();

  periph_bus_master #(
    .BASE_ADDR(32'hFFFF_F000),
    .RD_LAT(1)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  periph_bus_master #(
    .BASE_ADDR(32'hFFFF_F000),
    .RD_LAT(3)
  ) u_dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  logic        drv_req = 1'b0;
  logic        drv_we = 1'b0;
  logic [31:0] drv_addr = '0;
  logic [31:0] drv_wdata = '0;

  assign bus0.cpu_req = drv_req;
  assign bus0.cpu_we = drv_we;
  assign bus0.cpu_addr = drv_addr;
  assign bus0.cpu_wdata = drv_wdata;
  assign bus1.cpu_req = drv_req;
  assign bus1.cpu_we = drv_we;
  assign bus1.cpu_addr = drv_addr;
  assign bus1.cpu_wdata = drv_wdata;

  logic [3:0]  wen_a [2];
  logic [31:0] addr_a [2];
  logic [31:0] wdata_a [2];
  logic [31:0] rdata_a [2];
  logic        rdy_a [2];
  logic        busy_a [2];
  logic        err_a [2];

  assign wen_a[0] = bus0.per_wen;
  assign wen_a[1] = bus1.per_wen;
  assign addr_a[0] = bus0.per_addr;
  assign addr_a[1] = bus1.per_addr;
  assign wdata_a[0] = bus0.per_wdata;
  assign wdata_a[1] = bus1.per_wdata;
  assign rdata_a[0] = bus0.cpu_rdata;
  assign rdata_a[1] = bus1.cpu_rdata;
  assign rdy_a[0] = bus0.cpu_ready;
  assign rdy_a[1] = bus1.cpu_ready;
  assign busy_a[0] = bus0.cpu_busy;
  assign busy_a[1] = bus1.cpu_busy;
  assign err_a[0] = bus0.cpu_err;
  assign err_a[1] = bus1.cpu_err;

  // Responders: registered read; slot 2 mixes in a free-running count.
  logic [31:0] cyc = '0;
  logic [31:0] mem [2][4][4];
  logic [31:0] rr [2][4];

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 4; n++) begin
        if (wen_a[i][n]) mem[i][n][addr_a[i][3:2]] <= wdata_a[i];
        rr[i][n] <= mem[i][n][addr_a[i][3:2]]
                  + ((n == 2) ? cyc : 32'd0);
      end
    end
  end

  assign bus0.per_rdata = {rr[0][3], rr[0][2], rr[0][1], rr[0][0]};
  assign bus1.per_rdata = {rr[1][3], rr[1][2], rr[1][1], rr[1][0]};

  typedef struct {
    int          acc;
    int          rdy;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        q [2][$];
  logic [31:0] last_rd [2];
  logic [31:0] ref_mem [4][4];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h",
               nm, i, $time, act, exp);
    end
  endtask

  // Spec-level model: acc is the accept edge, ISSUE is cycle acc,
  // cpu_ready lands at acc+1 (write/miss) or acc+1+RD_LAT (read hit).
  task automatic push_exp(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int a);
    exp_t e;
    logic hit;
    logic [1:0] s;
    logic [1:0] w;
    hit = (addr[31:8] == 24'hFFFFF0) && (addr[7:6] == 2'b00);
    s = addr[5:4];
    w = addr[3:2];
    for (int i = 0; i < 2; i++) begin
      e.acc = a;
      e.addr = addr;
      e.wdata = wd;
      e.err = !hit;
      e.wen = (hit && we) ? (4'b0001 << s) : 4'b0000;
      e.rdy = (hit && !we) ? 1 + lat_of(i) : 1;
      if (!hit) e.rdata = '0;
      else if (we) e.rdata = last_rd[i];
      else e.rdata = ref_mem[s][w]
                   + ((s == 2'd2) ? 32'(a - 1 + lat_of(i)) : 32'd0);
      last_rd[i] = e.rdata;
      q[i].push_back(e);
    end
    if (hit && we) ref_mem[s][w] = wd;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   off;
    bit   has;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        has = (q[i].size() != 0);
        off = -1;
        if (has) begin
          e = q[i][0];
          off = int'(cyc) - e.acc;
        end
        chk("per_wen", i, 32'(wen_a[i]),
            (has && off == 0) ? 32'(e.wen) : 32'd0);
        if (has && off == 0) begin
          chk("per_addr", i, addr_a[i], e.addr);
          chk("per_wdata", i, wdata_a[i], e.wdata);
        end
        chk("cpu_busy", i, 32'(busy_a[i]),
            32'(has && off >= 0 && off <= e.rdy));
        chk("cpu_ready", i, 32'(rdy_a[i]),
            32'(has && off == e.rdy));
        if (rdy_a[i] && has && off == e.rdy) begin
          chk("cpu_rdata", i, rdata_a[i], e.rdata);
          chk("cpu_err", i, 32'(err_a[i]), 32'(e.err));
          void'(q[i].pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready"}, i, 32'(rdy_a[i]), 32'd0);
      chk({tag, "_busy"}, i, 32'(busy_a[i]), 32'd0);
      chk({tag, "_err"}, i, 32'(err_a[i]), 32'd0);
      chk({tag, "_wen"}, i, 32'(wen_a[i]), 32'd0);
      chk({tag, "_addr"}, i, addr_a[i], 32'd0);
      chk({tag, "_wdata"}, i, wdata_a[i], 32'd0);
      chk({tag, "_rdata"}, i, rdata_a[i], 32'd0);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout t=%0t", $time);
      q[0].delete();
      q[1].delete();
    end
  endtask

  task automatic scramble();
    drv_we = 1'($urandom);
    drv_addr = $urandom;
    drv_wdata = $urandom;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd);
    int a;
    a = int'(cyc) + 1;
    drv_req = 1'b1;
    drv_we = we;
    drv_addr = addr;
    drv_wdata = wd;
    push_exp(we, addr, wd, a);
    @(posedge clk);
    #1;
    drv_req = 1'b0;
    scramble();
    wait_drain();
  endtask

  initial begin
    int a;
    logic [31:0] ad;
    int r;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) begin
        issue(1'b1, 32'hFFFF_F000 | 32'(s << 4) | 32'(w << 2),
              $urandom);
      end
    end

    issue(1'b1, 32'hFFFF_F010, 32'hDEAD_BEEF);
    issue(1'b1, 32'hFFFF_F030, 32'h1234_5678);
    issue(1'b0, 32'hFFFF_F030, $urandom);
    issue(1'b0, 32'hFFFF_F010, $urandom);
    issue(1'b0, 32'h0000_1000, $urandom);
    issue(1'b1, 32'hFFFF_F040, $urandom);
    issue(1'b0, 32'hFFFF_F020, $urandom);
    issue(1'b0, 32'hFFFF_F02C, $urandom);

    // Request held high across a write then a read to slot 0.
    a = int'(cyc) + 1;
    drv_req = 1'b1;
    drv_we = 1'b1;
    drv_addr = 32'hFFFF_F004;
    drv_wdata = $urandom;
    push_exp(1'b1, drv_addr, drv_wdata, a);
    @(posedge clk);
    #1;
    drv_we = 1'b0;
    drv_addr = 32'hFFFF_F004;
    push_exp(1'b0, drv_addr, drv_wdata, a + 3);
    repeat (3) @(posedge clk);
    #1;
    drv_req = 1'b0;
    scramble();
    wait_drain();

    // Reset during the second WAIT cycle of the RD_LAT=3 master.
    a = int'(cyc) + 1;
    drv_req = 1'b1;
    drv_we = 1'b0;
    drv_addr = 32'hFFFF_F014;
    push_exp(1'b0, drv_addr, drv_wdata, a);
    @(posedge clk);
    #1;
    drv_req = 1'b0;
    scramble();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    q[1].delete();
    chk("rst_drained", 0, 32'(q[0].size()), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1;
    issue(1'b0, 32'hFFFF_F014, $urandom);
    issue(1'b0, 32'hFFFF_F028, $urandom);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) ad = $urandom;
      else ad = {24'hFFFFF0,
                 (r == 1) ? 2'($urandom_range(1, 3)) : 2'b00,
                 2'($urandom), 2'($urandom), 2'b00};
      issue(1'($urandom), ad, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator side of the memory-mapped peripheral bus (wen/addr/wdata out, registered rdata in).
- Sits between the CPU load/store path and up to 4 peripheral responders (timer, LEDs, switches, buttons).
- Accepts one CPU request at a time, decodes the target slot, drives the bus, and waits out the responder's registered read latency.
- Returns data with a single-cycle ready pulse, or an error for unmapped addresses.

Parameters:
- BASE_ADDR, 32'hFFFF_F000: peripheral window base; a hit requires addr[31:8] == BASE_ADDR[31:8].
- RD_LAT, 1: responder read latency in cycles from issue to valid rdata; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data; valid while cpu_ready = 1.
- cpu_err  out  1  unmapped access; valid while cpu_ready = 1.
- cpu_busy  out  1  high in every state except IDLE.
- per_wen  out  4  one-hot write enable per slot.
- per_addr  out  32  bus address to responders.
- per_wdata  out  32  bus write data.
- per_rdata  in  128  slot n read data on bits [32n+31:32n].

Behaviour:
- Reset (rst = 0 at a clk edge):
  - All outputs go to 0 and the state goes to IDLE.
  - Internal latches and the latency counter clear.
  - Reset mid-transaction aborts it: no cpu_ready pulse, and per_wen is 0 from the next edge.
- Decode:
  - hit = (cpu_addr[31:8] == BASE_ADDR[31:8]) && (cpu_addr[7:6] == 2'b00).
  - slot = cpu_addr[5:4]; each slot spans 16 bytes.
  - Decode uses the latched address.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cpu_busy = 0, cpu_ready = 0.
  - If cpu_req = 1 at an edge: latch we, addr and wdata, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - per_addr = latched addr, per_wdata = latched wdata.
  - per_wen[slot] = we & hit; all other per_wen bits are 0.
  - Next state: read hit goes to WAIT with counter = RD_LAT; write hit or any miss goes to RESP.
- WAIT:
  - per_wen = 0; per_addr and per_wdata hold.
  - Counter decrements each edge.
  - On the edge where the counter is 1: capture per_rdata[slot] into cpu_rdata, then go to RESP. WAIT therefore lasts exactly RD_LAT cycles.
- RESP (exactly 1 cycle):
  - cpu_ready = 1, cpu_err = ~hit.
  - Miss: cpu_rdata = 0 and no per_wen strobe was ever raised.
  - Write hit: cpu_rdata is left unchanged.
  - Next state: IDLE.
- cpu_err and cpu_ready return to 0 on the edge after RESP. cpu_rdata holds its value until the next read's RESP.
- Latency, counted from the edge where the request is sampled:
  - write or miss: cpu_ready is high in the 2nd cycle after.
  - read hit: cpu_ready is high in the (2 + RD_LAT)th cycle after.
- cpu_req in ISSUE, WAIT or RESP is ignored, with no queuing.
- A request held high continuously is re-accepted in the IDLE cycle following RESP, so there is at least one IDLE cycle between transactions.
- cpu_addr, cpu_we and cpu_wdata may change after acceptance without affecting the in-flight transaction.
- per_addr and per_wdata keep the last transaction's values while in IDLE.
- Bit-width rules: the counter is 4 bits; RD_LAT = 0 or RD_LAT > 15 is illegal and must be caught by an elaboration check.

Test Plan:
- Write hit: request sampled at edge E0 with cpu_addr = 32'hFFFF_F010, we = 1, wdata = 32'hDEAD_BEEF.
  - per_wen = 4'b0010 for exactly the cycle after E0, with per_addr = 32'hFFFF_F010 and per_wdata = 32'hDEAD_BEEF.
  - cpu_ready = 1 in cycle E0+2 with cpu_err = 0.
- Read hit, RD_LAT = 1: request to 32'hFFFF_F030 against a responder model whose rdata is registered one cycle and returns 32'h1234_5678.
  - cpu_ready = 1 in cycle E0+3 with cpu_rdata = 32'h1234_5678.
  - per_wen stays 0 throughout.
- Unmapped accesses: read of 32'h0000_1000, then write to 32'hFFFF_F040.
  - Each gives cpu_ready = 1 at E0+2 with cpu_err = 1; the read returns cpu_rdata = 0.
  - per_wen stays 4'b0000 throughout.
- Back-to-back: cpu_req held high for a write then a read to slot 0.
  - The second ISSUE occurs exactly 1 cycle after the first RESP's IDLE.
  - Exactly two cpu_ready pulses; cpu_busy = 0 only during the IDLE cycles.
- Reset mid-WAIT: build with RD_LAT = 3 and assert rst = 0 during the second WAIT cycle.
  - The next edge shows state IDLE with all outputs 0.
  - No cpu_ready pulse; a fresh read afterwards completes normally in 5 cycles.
- RD_LAT = 3 read of slot 2: the responder changes rdata each cycle.
  - The captured value is the one present in the 3rd cycle after ISSUE.
  - cpu_ready = 1 in cycle E0+5.
